// File: rtl/rand_pkg.sv
// Shared types and constants for the random-word arbiter around the 8-bit serial LFSR.
package rand_pkg;

    typedef enum logic [1:0] {
        S_SEED,
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [7:0] SEED_DEFAULT  = 8'hA5;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;
    localparam int         LOCKUP_THRESH = 16;

    // The all-zero LFSR state never leaves itself, so a zero seed is replaced.
    function automatic logic [7:0] guard_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    endfunction

endpackage

// File: rtl/rand_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_grant #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any
);

    localparam int IDW = $clog2(NUM_REQ);

    assign any = |req;

    // Walk from the farthest candidate back to the pointer so the nearest set bit wins.
    always_comb begin : pick
        int idx;
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant = '0;
        idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) grant = IDW'(idx);
        end
    end

endmodule

// File: rtl/rand_req_arbiter.sv
// Shares the serial LFSR among NUM_REQ requesters, collecting BITS bits per granted word.
// Optional build macro LOCKUP_RECOVER_EN adds a stuck-at-zero monitor and the lockup_flag output.
module rand_req_arbiter
    import rand_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         BITS     = 8,
    parameter logic [7:0] DEF_SEED = SEED_DEFAULT
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       rnd_valid,
    output logic [BITS-1:0]            rnd_data,
    output logic [$clog2(NUM_REQ)-1:0] rnd_id,
    input  logic                       rnd_ack,
    input  logic                       reseed,
    input  logic [7:0]                 seed_in,
    output logic                       lfsr_sel,
    output logic [7:0]                 lfsr_seed,
    input  logic                       lfsr_out
`ifdef LOCKUP_RECOVER_EN
    ,
    output logic                       lockup_flag
`endif
);

    localparam int                IDW      = $clog2(NUM_REQ);
    localparam int                CNTW     = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(BITS - 1);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, grant_idx, pick_idx;
    logic             pick_any;
    logic [BITS-1:0]  collect, collect_shifted;
    logic [CNTW-1:0]  cnt;
    logic [7:0]       seed_reg;
    logic             pending;
    logic             grant_go, shift_last, ack_go;

    rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign lfsr_sel  = (state != S_SEED);
    assign lfsr_seed = seed_reg;

    if (BITS == 1) begin : g_shift1
        assign collect_shifted = lfsr_out;
    end else begin : g_shiftn
        assign collect_shifted = {collect[BITS-2:0], lfsr_out};
    end

`ifdef LOCKUP_RECOVER_EN
    logic [4:0] zero_cnt, zero_cnt_nxt;
    logic       lockup_hit, resume_shift;

    always_comb begin
        zero_cnt_nxt = '0;
        if (lfsr_sel && !lfsr_out)
            zero_cnt_nxt = (zero_cnt == 5'(LOCKUP_THRESH)) ? zero_cnt : zero_cnt + 5'd1;
        lockup_hit = (zero_cnt_nxt == 5'(LOCKUP_THRESH)) && (state == S_IDLE || state == S_SHIFT);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            zero_cnt     <= '0;
            lockup_flag  <= 1'b0;
            resume_shift <= 1'b0;
        end else begin
            zero_cnt    <= zero_cnt_nxt;
            lockup_flag <= lockup_hit;
            if (state == S_SEED)
                resume_shift <= 1'b0;
            else if (lockup_hit && state == S_SHIFT)
                resume_shift <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        shift_last = 1'b0;
        ack_go     = 1'b0;
        case (state)
            S_SEED: begin
`ifdef LOCKUP_RECOVER_EN
                state_nxt = resume_shift ? S_SHIFT : S_IDLE;
`else
                state_nxt = S_IDLE;
`endif
            end
            S_IDLE: begin
                // A reseed, pending or arriving now, outranks any request.
                if (reseed || pending) begin
                    state_nxt = S_SEED;
                end else if (pick_any) begin
                    state_nxt = S_SHIFT;
                    grant_go  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt  = S_DONE;
                    shift_last = 1'b1;
                end
            end
            S_DONE: begin
                if (rnd_ack) begin
                    state_nxt = S_IDLE;
                    ack_go    = 1'b1;
                end
            end
            default: state_nxt = S_SEED;
        endcase
`ifdef LOCKUP_RECOVER_EN
        if (lockup_hit) begin
            state_nxt  = S_SEED;
            grant_go   = 1'b0;
            shift_last = 1'b0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= S_SEED;
            rr_ptr    <= '0;
            grant_idx <= '0;
            collect   <= '0;
            cnt       <= '0;
            seed_reg  <= guard_seed(DEF_SEED);
            pending   <= 1'b0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            rnd_id    <= '0;
        end else begin
            state <= state_nxt;

            if (reseed)
                seed_reg <= guard_seed(seed_in);
            if (state == S_IDLE && state_nxt == S_SEED)
                pending <= 1'b0;
            else if (reseed)
                pending <= 1'b1;

            if (grant_go) begin
                grant_idx <= pick_idx;
                cnt       <= '0;
                collect   <= '0;
            end

            if (state == S_SHIFT) begin
                if (state_nxt == S_SEED) begin
                    cnt     <= '0;
                    collect <= '0;
                end else begin
                    cnt     <= cnt + CNTW'(1);
                    collect <= collect_shifted;
                end
            end

            if (shift_last) begin
                rnd_valid <= 1'b1;
                rnd_data  <= collect_shifted;
                rnd_id    <= grant_idx;
            end

            if (ack_go) begin
                rnd_valid <= 1'b0;
                rr_ptr    <= IDW'((int'(grant_idx) + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Directed bench for rand_req_arbiter with an external 8-bit LFSR and a scoreboard of expected words.
module tb_rand_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int BITS    = 8;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         vcyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] req = '0;
    logic       rnd_valid;
    logic [7:0] rnd_data;
    logic [1:0] rnd_id;
    logic       rnd_ack = 1'b0;
    logic       reseed = 1'b0;
    logic [7:0] seed_in = '0;
    logic       lfsr_sel;
    logic [7:0] lfsr_seed;
    logic       lfsr_out;
`ifdef LOCKUP_RECOVER_EN
    logic       lockup_flag;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic [1:0] rr_ids [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [7:0] w;

    logic [7:0] env_lfsr = 8'hFF;
    logic       force_en = 1'b0;
    logic       force_bit = 1'b0;

    always #5 clk = ~clk;

    rand_req_arbiter #(.NUM_REQ(NUM_REQ), .BITS(BITS), .DEF_SEED(8'hA5)) dut (
        .clk       (clk),
        .clr       (clr),
        .req       (req),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_id    (rnd_id),
        .rnd_ack   (rnd_ack),
        .reseed    (reseed),
        .seed_in   (seed_in),
        .lfsr_sel  (lfsr_sel),
        .lfsr_seed (lfsr_seed),
        .lfsr_out  (lfsr_out)
`ifdef LOCKUP_RECOVER_EN
        ,
        .lockup_flag (lockup_flag)
`endif
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Word collected when the grant happens in a cycle where the LFSR holds s.
    function automatic logic [7:0] lfsr_word(input logic [7:0] s);
        logic [7:0] r;
        logic [7:0] acc;
        r   = s;
        acc = '0;
        for (int i = 0; i < BITS; i++) begin
            r   = lfsr_step(r);
            acc = {acc[6:0], r[7]};
        end
        return acc;
    endfunction

    always @(posedge clk) env_lfsr <= lfsr_sel ? lfsr_step(env_lfsr) : lfsr_seed;
    always @(posedge clk) cyc <= cyc + 1;
    assign lfsr_out = force_en ? force_bit : env_lfsr[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.vcyc = cyc + BITS + 1;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!rnd_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("valid_timeout", 32'(rnd_valid), 32'd1);
    endtask

    // Scoreboard consumer: compares each new word against the oldest expectation.
    initial begin : monitor
        exp_t e;
        logic in_word;
        in_word = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (clr && rnd_valid && !in_word) begin
                in_word = 1'b1;
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("word_id", 32'(rnd_id), 32'(e.id));
                    check("word_data", 32'(rnd_data), 32'(e.data));
                    check("word_cycle", 32'(cyc), 32'(e.vcyc));
                end
            end
            if (rnd_valid && rnd_ack) in_word = 1'b0;
        end
    end

    initial begin
        #2 clr = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_data", 32'(rnd_data), 32'd0);
        check("rst_id", 32'(rnd_id), 32'd0);
        check("rst_sel", 32'(lfsr_sel), 32'd0);
        check("rst_seed", 32'(lfsr_seed), 32'hA5);

        clr = 1'b1;
        #1;
        check("seed_cycle_sel", 32'(lfsr_sel), 32'd0);
        check("seed_cycle_seed", 32'(lfsr_seed), 32'hA5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_sel", 32'(lfsr_sel), 32'd1);
            check("idle_valid", 32'(rnd_valid), 32'd0);
        end

        // Zero seed is substituted; the next word follows an LFSR seeded 8'h01.
        reseed  = 1'b1;
        seed_in = 8'h00;
        tick();
        reseed  = 1'b0;
        rnd_ack = 1'b1;
        check("zseed_sel", 32'(lfsr_sel), 32'd0);
        check("zseed_seed", 32'(lfsr_seed), 32'h01);
        tick();
        check("zseed_back_sel", 32'(lfsr_sel), 32'd1);
        check("ack_idle_valid", 32'(rnd_valid), 32'd0);
        req = 4'b0001;
        push(2'd0, lfsr_word(8'h01));
        wait_valid(20);
        req = '0;
        tick();

        // Round robin over requesters 1 and 3 with ack tied high.
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            push(rr_ids[k], lfsr_word(env_lfsr));
            repeat (BITS + 2) tick();
        end
        req = '0;
        rnd_ack = 1'b0;
        tick();

        // Delayed ack: word and id hold while waiting.
        req = 4'b0100;
        w = lfsr_word(env_lfsr);
        push(2'd2, w);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(rnd_valid), 32'd1);
            check("hold_data", 32'(rnd_data), 32'(w));
            check("hold_id", 32'(rnd_id), 32'd2);
            if (i == 4) begin
                rnd_ack = 1'b1;
                req     = '0;
            end
            tick();
        end
        check("hold_drop", 32'(rnd_valid), 32'd0);
        rnd_ack = 1'b0;

        // Reseed during a shift waits until the word is acknowledged.
        req = 4'b0001;
        push(2'd0, lfsr_word(env_lfsr));
        repeat (3) tick();
        reseed  = 1'b1;
        seed_in = 8'h3C;
        tick();
        reseed = 1'b0;
        check("rs_shift_sel", 32'(lfsr_sel), 32'd1);
        wait_valid(20);
        check("rs_done_sel", 32'(lfsr_sel), 32'd1);
        rnd_ack = 1'b1;
        tick();
        check("rs_idle_sel", 32'(lfsr_sel), 32'd1);
        tick();
        check("rs_load_sel", 32'(lfsr_sel), 32'd0);
        check("rs_load_seed", 32'(lfsr_seed), 32'h3C);
        tick();
        check("rs_after_sel", 32'(lfsr_sel), 32'd1);
        push(2'd0, lfsr_word(8'h3C));
        wait_valid(20);
        req = '0;
        tick();
        rnd_ack = 1'b0;

        // Sixteen forced zeros while idle.
        force_en  = 1'b1;
        force_bit = 1'b1;
        tick();
        force_bit = 1'b0;
        repeat (15) tick();
        check("lock_pre_sel", 32'(lfsr_sel), 32'd1);
        tick();
`ifdef LOCKUP_RECOVER_EN
        check("lock_sel", 32'(lfsr_sel), 32'd0);
        check("lock_flag", 32'(lockup_flag), 32'd1);
        tick();
        check("lock_after_sel", 32'(lfsr_sel), 32'd1);
        check("lock_flag_clr", 32'(lockup_flag), 32'd0);
`else
        check("nolock_sel", 32'(lfsr_sel), 32'd1);
        repeat (4) tick();
        check("nolock_sel_late", 32'(lfsr_sel), 32'd1);
`endif
        force_en = 1'b0;
        repeat (3) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_valid", 32'(rnd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rand_req_arbiter.md
Name: rand_req_arbiter

Overview:
- Sequences and shares the 8-bit serial LFSR random source among NUM_REQ game-logic requesters (spawn lanes, item pickers).
- Owns the generator's seed/shift select and guarantees a nonzero seed load after reset.
- Collects BITS serial bits per request into a word and returns it to the round-robin-granted requester over a valid/ack handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BITS, 8, bits collected per random word (1..16)
- DEF_SEED, 8'hA5, seed loaded after reset

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  level request per requester; held until served
- rnd_valid  out  1  random word available
- rnd_data  out  BITS  random word
- rnd_id  out  $clog2(NUM_REQ)  index of served requester
- rnd_ack  in  1  consumer accepts word (valid && ack = transfer)
- reseed  in  1  one-cycle pulse requesting a seed reload
- seed_in  in  8  seed captured with reseed
- lfsr_sel  out  1  to LFSR select: 0 = load seed, 1 = shift
- lfsr_seed  out  8  to LFSR seed input
- lfsr_out  in  1  LFSR serial output

Behaviour:
- Reset (clr low, async):
  - state=S_SEED; rnd_valid=0; rnd_data=0; rnd_id=0; rr pointer=0.
  - seed reg=DEF_SEED; reseed pending=0; lfsr_sel=0; lfsr_seed=DEF_SEED.
- Seed zero guard: a captured seed of 8'h00 is stored as 8'h01, since the all-zero LFSR state locks.
- States:
  - S_SEED: lfsr_sel=0 for exactly one cycle, then S_IDLE.
  - S_IDLE: lfsr_sel=1 (free-running).
    - Pending reseed → S_SEED; it has priority over requests.
    - Else any req bit set → grant first set bit at or after rr pointer (wrapping) → S_SHIFT.
  - S_SHIFT: lfsr_sel=1 for BITS cycles.
    - Each cycle shift lfsr_out into LSB of collect reg (first bit ends in MSB).
    - Counter 0..BITS-1; at BITS-1 → S_DONE.
  - S_DONE: rnd_valid=1, rnd_data=collect reg, rnd_id=granted index.
    - data/id stable while valid and !ack.
    - On ack: valid drops next cycle, rr pointer=grant+1 (mod NUM_REQ), → S_IDLE.
- Latency: request seen in S_IDLE → rnd_valid high BITS+1 cycles later (grant 1 cycle + BITS shifts). Minimum spacing between transfers is BITS+2 cycles.
- reseed pulse in any state other than S_SEED:
  - seed_in captured immediately; pending flag set.
  - Served on next S_IDLE; never aborts S_SHIFT or S_DONE.
  - A second pulse before service overwrites the captured seed.
- reseed during S_SEED: captured and pending; reload repeats once.
- req deasserted after grant: the word is still produced and delivered with that id.
- rnd_ack while rnd_valid=0: ignored.
- Outputs are registered except lfsr_sel and lfsr_seed, which decode from state and seed reg.

Optional Feature:
- LOCKUP_RECOVER_EN defined:
  - 5-bit counter of consecutive lfsr_out==0 cycles while lfsr_sel=1.
  - At 16, force a reload of the stored seed: S_SEED from S_IDLE; from S_SHIFT, restart S_SHIFT after the reload cycle, counter and collect reg cleared, grant kept.
  - A maximal 8-bit sequence cannot produce 16 zeros, so this only fires if the LFSR was cleared independently.
  - Exposes output lockup_flag: 1-cycle pulse on recovery.
- Undefined: no monitor, no lockup_flag port, no recovery.

Decomposition:
- Shared package rand_pkg:
  - state enum S_SEED/S_IDLE/S_SHIFT/S_DONE
  - DEF_SEED constant and zero-seed substitute 8'h01
  - lockup threshold 16
- One natural sub-module: rr_grant (NUM_REQ-wide round-robin priority picker).
  - Inputs: req, pointer. Outputs: grant index, any.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset release, no req → lfsr_sel=0 for exactly 1 cycle with lfsr_seed=8'hA5, then lfsr_sel stays 1; rnd_valid=0.
- reseed=1, seed_in=8'h00 in S_IDLE → next cycle lfsr_sel=0, lfsr_seed=8'h01; rnd_data matches a bit-accurate LFSR model seeded 8'h01.
- req=4'b1010 held, rnd_ack tied 1 → rnd_id sequence 1,3,1,3; valid pulses spaced BITS+2=10 cycles.
- Single req[2], rnd_ack delayed 5 cycles → rnd_valid high 5 cycles; rnd_data and rnd_id=2 constant throughout.
- reseed mid-S_SHIFT with seed_in=8'h3C → current word completes and delivers; seed load (lfsr_seed=8'h3C) occurs only after ack, before the next grant.
- LOCKUP_RECOVER_EN: force lfsr_out=0 for 16 cycles in S_IDLE → lockup_flag pulses, lfsr_sel=0 one cycle; without macro → no reload.
